// File: rtl/ws2812_cmd_sched_if.sv
// iomem bus bundle between the SoC master and the ws2812 command scheduler.
// The master drives the request fields; the scheduler returns ready and read data.
interface ws2812_cmd_sched_if;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;

    modport master (
        output iomem_valid,
        output iomem_wstrb,
        output iomem_addr,
        output iomem_wdata,
        input  iomem_ready,
        input  iomem_rdata
    );

    modport slave (
        input  iomem_valid,
        input  iomem_wstrb,
        input  iomem_addr,
        input  iomem_wdata,
        output iomem_ready,
        output iomem_rdata
    );
endinterface

// File: rtl/ws2812_cmd_sched.sv
// Buffers CPU LED-update commands in a FIFO and drains them to the ws2812 driver,
// forcing a fixed idle gap after every write pulse. CMD at +0, STATUS at +4.
module ws2812_cmd_sched #(
    parameter logic [31:0] BASE_ADDR  = 32'h0400_0000,
    parameter int unsigned NUM_LEDS   = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned GAP_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    ws2812_cmd_sched_if.slave    bus,
    output logic [7:0]           ws_led_num,
    output logic [23:0]          ws_rgb_data,
    output logic                 ws_write,
    output logic [6:0]           fifo_level
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned LvlW = PtrW + 1;
    localparam int unsigned CntW = $clog2(GAP_CYCLES + 1);
    localparam logic [LvlW-1:0] DepthLvl = LvlW'(FIFO_DEPTH);
    localparam logic [CntW-1:0] GapInit  = CntW'(GAP_CYCLES);

    typedef enum logic [1:0] {StIdle, StPulse, StGap} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]   level_q, level_d;
    logic              err_idx_q, err_idx_d;
    logic              err_strb_q, err_strb_d;
    logic              ready_q, ready_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [7:0]        led_num_q, led_num_d;
    logic [23:0]       rgb_q, rgb_d;
    logic              write_q, write_d;
    logic [31:0]       mem_q [FIFO_DEPTH];

    logic        hit, sel_status, is_write, full, empty, busy, push, pop;
    logic [31:0] status_word;
    logic        unused_addr;

    assign unused_addr = ^bus.iomem_addr[1:0];

    // ready_q gates the decode so every access sees ready drop for a cycle.
    assign hit        = bus.iomem_valid && !ready_q &&
                        (bus.iomem_addr[31:3] == BASE_ADDR[31:3]);
    assign sel_status = bus.iomem_addr[2];
    assign is_write   = |bus.iomem_wstrb;
    assign full       = (level_q == DepthLvl);
    assign empty      = (level_q == '0);
    assign busy       = (state_q != StIdle);

    assign status_word = {7'd0, busy, 6'd0, err_strb_q, err_idx_q, 6'd0,
                          empty, full, 1'b0, 7'(level_q)};

    always_comb begin
        ready_d    = 1'b0;
        rdata_d    = '0;
        push       = 1'b0;
        err_idx_d  = err_idx_q;
        err_strb_d = err_strb_q;
        if (hit) begin
            if (sel_status) begin
                ready_d = 1'b1;
                if (is_write) begin
                    if (bus.iomem_wstrb[2] && bus.iomem_wdata[16]) err_idx_d  = 1'b0;
                    if (bus.iomem_wstrb[2] && bus.iomem_wdata[17]) err_strb_d = 1'b0;
                end else begin
                    rdata_d = status_word;
                end
            end else if (!is_write) begin
                ready_d = 1'b1;
            end else if (bus.iomem_wstrb != 4'hF) begin
                ready_d    = 1'b1;
                err_strb_d = 1'b1;
            end else if ({24'd0, bus.iomem_wdata[7:0]} >= NUM_LEDS) begin
                ready_d   = 1'b1;
                err_idx_d = 1'b1;
            end else if (!full) begin
                // Full uses the registered level, so a same-cycle pop never frees a slot.
                ready_d = 1'b1;
                push    = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pop       = 1'b0;
        write_d   = 1'b0;
        led_num_d = led_num_q;
        rgb_d     = rgb_q;
        unique case (state_q)
            StIdle: begin
                if (!empty) state_d = StPulse;
            end
            StPulse: begin
                write_d   = 1'b1;
                led_num_d = mem_q[rd_ptr_q][7:0];
                rgb_d     = mem_q[rd_ptr_q][31:8];
                pop       = 1'b1;
                cnt_d     = GapInit;
                state_d   = StGap;
            end
            StGap: begin
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + LvlW'(1);
            2'b01:   level_d = level_q - LvlW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            err_idx_q  <= 1'b0;
            err_strb_q <= 1'b0;
            ready_q    <= 1'b0;
            rdata_q    <= '0;
            led_num_q  <= '0;
            rgb_q      <= '0;
            write_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            err_idx_q  <= err_idx_d;
            err_strb_q <= err_strb_d;
            ready_q    <= ready_d;
            rdata_q    <= rdata_d;
            led_num_q  <= led_num_d;
            rgb_q      <= rgb_d;
            write_q    <= write_d;
        end
    end

    always_ff @(posedge clk) begin
        if (resetn && push) mem_q[wr_ptr_q] <= bus.iomem_wdata;
    end

    assign bus.iomem_ready = ready_q;
    assign bus.iomem_rdata = rdata_q;
    assign ws_led_num      = led_num_q;
    assign ws_rgb_data     = rgb_q;
    assign ws_write        = write_q;
    assign fifo_level      = 7'(level_q);

endmodule

// File: tb/tb_ws2812_cmd_sched.sv
// Randomised bench for ws2812_cmd_sched against a schedule-level reference model:
// each accepted command gets an ack cycle and a pulse cycle, from which level/busy/stall follow.
module tb_ws2812_cmd_sched;

    localparam logic [31:0] Base    = 32'h0400_0000;
    localparam int          NumLeds = 8;
    localparam int          Depth   = 4;
    localparam int          Gap     = 4;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    ws2812_cmd_sched_if bus_if ();
    logic [7:0]  ws_led_num;
    logic [23:0] ws_rgb_data;
    logic        ws_write;
    logic [6:0]  fifo_level;

    ws2812_cmd_sched #(
        .BASE_ADDR  (Base),
        .NUM_LEDS   (NumLeds),
        .FIFO_DEPTH (Depth),
        .GAP_CYCLES (Gap)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .bus         (bus_if),
        .ws_led_num  (ws_led_num),
        .ws_rgb_data (ws_rgb_data),
        .ws_write    (ws_write),
        .fifo_level  (fifo_level)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        int          ack;
        int          sched;
        logic [7:0]  num;
        logic [23:0] rgb;
    } ent_t;

    ent_t        hist[$];
    ent_t        pend[$];
    int          last_sched = -1000;
    int          last_ack   = -10;
    logic [7:0]  last_num   = '0;
    logic [23:0] last_rgb   = '0;
    bit          m_err_idx  = 1'b0;
    bit          m_err_strb = 1'b0;
    bit          mon_on     = 1'b0;

    // Entry occupies the FIFO from its ack cycle until its pulse cycle.
    function automatic int model_level(input int s);
        int n = 0;
        foreach (hist[i]) if (hist[i].ack <= s && hist[i].sched > s) n++;
        return n;
    endfunction

    function automatic bit model_busy(input int s);
        foreach (hist[i]) if (s >= hist[i].sched - 1 && s <= hist[i].sched + Gap - 1) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_status(input int s);
        int          lv;
        logic [31:0] w;
        lv      = model_level(s);
        w       = '0;
        w[6:0]  = lv[6:0];
        w[8]    = (lv == Depth);
        w[9]    = (lv == 0);
        w[16]   = m_err_idx;
        w[17]   = m_err_strb;
        w[24]   = model_busy(s);
        return w;
    endfunction

    always @(negedge clk) begin
        if (mon_on) begin
            if (pend.size() > 0 && pend[0].sched == cyc) begin
                check_eq("pulse", 32'(ws_write), 32'd1);
                check_eq("pulse_num", 32'(ws_led_num), 32'(pend[0].num));
                check_eq("pulse_rgb", 32'(ws_rgb_data), 32'(pend[0].rgb));
                last_num = pend[0].num;
                last_rgb = pend[0].rgb;
                void'(pend.pop_front());
            end else begin
                check_eq("no_pulse", 32'(ws_write), 32'd0);
                check_eq("hold_num", 32'(ws_led_num), 32'(last_num));
                check_eq("hold_rgb", 32'(ws_rgb_data), 32'(last_rgb));
            end
            check_eq("level", 32'(fifo_level), 32'(model_level(cyc)));
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_xfer(input logic [31:0] addr, input logic [3:0] strb,
                            input logic [31:0] wdata);
        int          s0, a, exp_a;
        bit          got;
        bit          is_cmd, is_push;
        logic [31:0] rd;
        ent_t        e;
        got = 1'b0;
        a   = 0;
        rd  = '0;
        s0  = (cyc == last_ack) ? cyc + 1 : cyc;
        bus_if.iomem_valid = 1'b1;
        bus_if.iomem_addr  = addr;
        bus_if.iomem_wstrb = strb;
        bus_if.iomem_wdata = wdata;
        for (int k = 0; k < 300 && !got; k++) begin
            @(posedge clk);
            #1;
            if (bus_if.iomem_ready === 1'b1) begin
                got = 1'b1;
                a   = cyc;
                rd  = bus_if.iomem_rdata;
            end
        end
        bus_if.iomem_valid = 1'b0;
        bus_if.iomem_wstrb = '0;
        check_eq("ack_seen", 32'(got), 32'd1);
        if (!got) return;
        last_ack = a;
        is_cmd  = (addr[2] == 1'b0);
        is_push = is_cmd && strb == 4'hF && wdata[7:0] < NumLeds;
        if (is_push) begin
            exp_a = s0;
            while (model_level(exp_a) >= Depth && exp_a < s0 + 400) exp_a++;
            exp_a++;
        end else begin
            exp_a = s0 + 1;
        end
        check_eq("ack_cyc", 32'(a), 32'(exp_a));
        if (strb == 4'h0) begin
            if (is_cmd) check_eq("cmd_rd", rd, 32'd0);
            else        check_eq("status_rd", rd, model_status(a - 1));
        end
        if (is_cmd && strb != 4'h0) begin
            if (strb != 4'hF) begin
                m_err_strb = 1'b1;
            end else if (wdata[7:0] >= NumLeds) begin
                m_err_idx = 1'b1;
            end else begin
                e.ack   = a;
                e.sched = (last_sched + Gap + 2 > a + 2) ? last_sched + Gap + 2 : a + 2;
                e.num   = wdata[7:0];
                e.rgb   = wdata[31:8];
                last_sched = e.sched;
                hist.push_back(e);
                pend.push_back(e);
            end
        end else if (!is_cmd && strb[2]) begin
            if (wdata[16]) m_err_idx  = 1'b0;
            if (wdata[17]) m_err_strb = 1'b0;
        end
    endtask

    task automatic status_rd();
        bus_xfer(Base + 32'd4, 4'h0, 32'd0);
    endtask

    task automatic push_cmd(input logic [7:0] num);
        logic [23:0] rgb;
        rgb = 24'($urandom);
        bus_xfer(Base, 4'hF, {rgb, num});
    endtask

    // Reset is applied in the current cycle; the model forgets everything once the DUT has.
    task automatic do_reset();
        resetn = 1'b0;
        @(posedge clk);
        #1;
        hist.delete();
        pend.delete();
        last_sched = -1000;
        last_num   = '0;
        last_rgb   = '0;
        m_err_idx  = 1'b0;
        m_err_strb = 1'b0;
        check_eq("rst_ready", 32'(bus_if.iomem_ready), 32'd0);
        check_eq("rst_rdata", bus_if.iomem_rdata, 32'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    task automatic miss_probe(input logic [31:0] addr);
        int seen = 0;
        @(posedge clk);
        #1;
        bus_if.iomem_valid = 1'b1;
        bus_if.iomem_addr  = addr;
        bus_if.iomem_wstrb = 4'($urandom_range(0, 15));
        bus_if.iomem_wdata = $urandom;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (bus_if.iomem_ready !== 1'b0) seen++;
        end
        bus_if.iomem_valid = 1'b0;
        bus_if.iomem_wstrb = '0;
        check_eq("miss_ready", 32'(seen), 32'd0);
    endtask

    initial begin
        int r;
        bus_if.iomem_valid = 1'b0;
        bus_if.iomem_wstrb = '0;
        bus_if.iomem_addr  = '0;
        bus_if.iomem_wdata = '0;
        idle(3);
        check_eq("rst_write", 32'(ws_write), 32'd0);
        check_eq("rst_level", 32'(fifo_level), 32'd0);
        check_eq("rst_num", 32'(ws_led_num), 32'd0);
        check_eq("rst_rgb", 32'(ws_rgb_data), 32'd0);
        check_eq("rst_ready", 32'(bus_if.iomem_ready), 32'd0);
        check_eq("rst_rdata", bus_if.iomem_rdata, 32'd0);
        mon_on = 1'b1;
        resetn = 1'b1;
        idle(2);

        // Single command, then status once the gap has elapsed.
        bus_xfer(Base, 4'hF, 32'h00FF_0003);
        idle(12);
        status_rd();

        // Six back-to-back pushes overrun a four-deep FIFO.
        for (int i = 0; i < 6; i++) push_cmd(8'(i));
        idle(40);

        // Index error and its W1C clear.
        bus_xfer(Base, 4'hF, 32'h0012_3408);
        status_rd();
        bus_xfer(Base + 32'd4, 4'hF, 32'h0001_0000);
        status_rd();

        // Partial strobe error leaves the FIFO alone.
        bus_xfer(Base, 4'b0011, 32'h00AB_CD01);
        status_rd();
        idle(10);

        // Second push lands while the first is in its pulse cycle; then wrap 3x.
        push_cmd(8'd1);
        push_cmd(8'd2);
        for (int i = 0; i < 3 * Depth; i++) push_cmd(8'(i % NumLeds));
        idle(80);

        // Reset in the gap with three commands still queued.
        for (int i = 0; i < 4; i++) push_cmd(8'(7 - i));
        do_reset();
        status_rd();
        idle(30);

        miss_probe(32'h0300_0000);
        miss_probe(Base + 32'd8);

        for (int it = 0; it < 400; it++) begin
            r = $urandom_range(0, 99);
            if (r < 55)      push_cmd(8'($urandom_range(0, NumLeds - 1)));
            else if (r < 63) push_cmd(8'($urandom_range(NumLeds, 255)));
            else if (r < 70) bus_xfer(Base, 4'($urandom_range(1, 14)), $urandom);
            else if (r < 82) status_rd();
            else if (r < 90) bus_xfer(Base + 32'd4, 4'($urandom_range(1, 15)), $urandom);
            else if (r < 94) bus_xfer(Base, 4'h0, $urandom);
            else if (r < 97) miss_probe(($urandom_range(0, 1) == 0) ? 32'h0300_0000 : Base + 32'd8);
            else             do_reset();
            idle($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) idle(20);
        end

        for (int k = 0; k < 2000 && pend.size() > 0; k++) idle(1);
        check_eq("drained", 32'(pend.size()), 32'd0);
        idle(Gap + 4);
        status_rd();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
